// File: rtl/seven_seg_scan.sv
// rtl/seven_seg_scan.sv - time-multiplexed multi-digit 7-segment display driver
// Shadow-latched digit codes, scanned one digit per PRESCALE cycles onto a shared segment bus.
module seven_seg_scan #(
  parameter int DIGITS   = 4,
  parameter int PRESCALE = 1000,
  parameter int HEX_MODE = 0
) (
  input  logic                  i_w_clk,
  input  logic                  i_w_reset,
  input  logic [4*DIGITS-1:0]   i_w_in,
  input  logic                  i_w_load,
  input  logic                  i_w_lzs,
  output logic [6:0]            o_w_7seg,
  output logic [DIGITS-1:0]     o_w_an,
  output logic                  o_w_frame
);

  localparam int CNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PRESCALE - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

  logic [CNT_W-1:0]     cnt;
  logic [IDX_W-1:0]     idx;
  logic [4*DIGITS-1:0]  shadow;
  logic                 wrap_seen;
  logic                 tick;
  logic                 wrap;
  logic [3:0]           nibble;
  logic                 blank;
  logic                 upper_zero;
  logic [6:0]           seg_next;
  logic [DIGITS-1:0]    an_next;

  assign tick = (cnt == CNT_LAST);
  assign wrap = tick && (idx == IDX_LAST);

  function automatic logic [6:0] decode(input logic [3:0] code);
    logic [6:0] seg;
    case (code)
      4'd0:    seg = 7'd63;
      4'd1:    seg = 7'd6;
      4'd2:    seg = 7'd91;
      4'd3:    seg = 7'd79;
      4'd4:    seg = 7'd102;
      4'd5:    seg = 7'd109;
      4'd6:    seg = 7'd125;
      4'd7:    seg = 7'd7;
      4'd8:    seg = 7'd127;
      4'd9:    seg = 7'd111;
      4'd10:   seg = 7'd119;
      4'd11:   seg = 7'd124;
      4'd12:   seg = 7'd57;
      4'd13:   seg = 7'd94;
      4'd14:   seg = 7'd121;
      default: seg = 7'd113;
    endcase
    if (HEX_MODE == 0 && code > 4'd9) begin
      seg = 7'd0;
    end
    return seg;
  endfunction

  // Walk from the top digit down so upper_zero covers this nibble and every one above it.
  always_comb begin
    nibble     = 4'd0;
    blank      = 1'b0;
    upper_zero = 1'b1;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      upper_zero = upper_zero && (shadow[4*k +: 4] == 4'd0);
      if (idx == IDX_W'(k)) begin
        nibble = shadow[4*k +: 4];
        blank  = i_w_lzs && (k != 0) && upper_zero;
      end
    end
  end

  always_comb begin
    seg_next = blank ? 7'd0 : decode(nibble);
    an_next  = '1;
    for (int k = 0; k < DIGITS; k++) begin
      an_next[k] = (idx != IDX_W'(k));
    end
  end

  // Outputs lag idx by one edge, so the frame pulse is delayed one edge behind the wrap.
  always_ff @(posedge i_w_clk) begin
    if (i_w_reset) begin
      cnt       <= '0;
      idx       <= '0;
      shadow    <= '0;
      wrap_seen <= 1'b0;
      o_w_7seg  <= 7'd0;
      o_w_an    <= '1;
      o_w_frame <= 1'b0;
    end else begin
      cnt <= tick ? '0 : cnt + 1'b1;
      if (tick) begin
        idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
      end
      if (i_w_load) begin
        shadow <= i_w_in;
      end
      wrap_seen <= wrap;
      o_w_frame <= wrap_seen;
      o_w_7seg  <= seg_next;
      o_w_an    <= an_next;
    end
  end

endmodule

// File: doc/seven_seg_scan.md
# seven_seg_scan

Parametrised, time-multiplexed multi-digit 7-segment display driver. Latches a packed vector of 4-bit digit codes into a shadow register on a load strobe. Scans the digits one at a time at a programmable rate, driving one shared segment bus and one-hot active-low digit enables. Sits between the datapath (counters, ALU results) and the board's common-anode display, replacing per-digit combinational decoders.

## Interface
- DIGITS, 4: number of display digits; legal range 1..8.
- PRESCALE, 1000: clock cycles each digit stays selected; legal range >= 1.
- HEX_MODE, 0: 0 = decimal (codes 10..15 blank), 1 = hexadecimal (codes 10..15 show A..F).

Ports:
- i_w_clk  in  1  clock; all state updates on its rising edge.
- i_w_reset  in  1  reset, synchronous and active-high.
- i_w_in  in  4*DIGITS  digit codes; nibble k (bits 4k+3..4k) is digit k; digit 0 is least significant (rightmost).
- i_w_load  in  1  when high at a clock edge, i_w_in is copied into the shadow register.
- i_w_lzs  in  1  leading-zero suppression enable; sampled every cycle.
- o_w_7seg  out  7  segments {g,f,e,d,c,b,a}; 1 = lit.
- o_w_an  out  DIGITS  digit enables, active-low, at most one bit low.
- o_w_frame  out  1  one-cycle pulse when the scan wraps from digit DIGITS-1 to digit 0.

## Operation
- Shadow register (4*DIGITS bits): reset to 0; loaded from i_w_in on any edge with i_w_load=1; otherwise holds. The display shows only shadow contents and never i_w_in directly.
- Prescaler counts 0..PRESCALE-1. At PRESCALE-1 it wraps to 0 and the digit index advances.
- Digit index counts 0..DIGITS-1 and wraps to 0. DIGITS=1 keeps the index at 0, and o_w_frame pulses on every prescaler wrap.
- Decode of nibble at the current index, as decimal codes 0..F: 63, 6, 91, 79, 102, 109, 125, 7, 127, 111, 119, 124, 57, 94, 121, 113.
  - When HEX_MODE=0, codes 10..15 produce 0 (blank).
- Leading-zero suppression applies when i_w_lzs=1. A digit k>0 is blanked (o_w_7seg=0) when its nibble and all nibbles above it are 0. Digit 0 is never suppressed, so an all-zero value shows a single "0".
- o_w_an: bit k is 0 when index=k, else 1. Blanked digits keep their enable low so the scan duty stays uniform.
- Outputs are registered and reflect the index, shadow and i_w_lzs values present before the edge.

## Timing
- Reset (synchronous): prescaler=0, index=0, shadow=0, o_w_7seg=0, o_w_an=all ones, o_w_frame=0.
- First edge with reset low: o_w_an selects digit 0 and o_w_7seg=63 (shadow 0).
- Each digit is selected for exactly PRESCALE consecutive cycles. Frame period is DIGITS*PRESCALE cycles.
- o_w_frame is high for the single cycle in which o_w_an first shows digit 0 after digit DIGITS-1. It is not asserted on the first cycle after reset.
- Load latency: a load at edge t changes o_w_7seg at edge t+1 if that digit is selected then. Loading does not reset the prescaler or the index.
- Load on the same edge as an index advance: the newly selected digit shows the new shadow value one edge later. No mixed old/new nibble is ever displayed for one digit slot.
- Reset mid-scan: the next edge forces reset values regardless of i_w_load. Scan restarts at digit 0 with a full PRESCALE period.
- Reset has priority over load.

## Test plan
All scenarios use DIGITS=4 and PRESCALE=4 unless stated.
- Reset, then release with no load -> o_w_an=1110 with o_w_7seg=63 for 4 cycles, then 1101, 1011, 0111 (each 4 cycles, o_w_7seg=63), then o_w_frame=1 with o_w_an=1110.
- Load i_w_in=16'h1234 with HEX_MODE=0 -> digit 0..3 slots show 102, 79, 91, 6. Codes 0..9 checked individually on digit 0 match the table.
- HEX_MODE=1, load 16'hABCF -> digits 0..3 show 113, 57, 124, 119. With HEX_MODE=0, the same load gives 0 in all four slots.
- i_w_lzs=1, load 16'h0050 -> digits 3 and 2 give 0, digit 1 gives 109, digit 0 gives 63. Load 16'h0000 -> only digit 0 is lit (63). Drop i_w_lzs -> all four show 63 from the next edge.
- Change i_w_in every cycle with i_w_load=0 -> o_w_7seg unchanged. Pulse i_w_load during digit 2's slot -> digit 2 updates one edge later. Index and prescaler timing are unaffected.
- Assert i_w_reset for one cycle mid-slot with i_w_load=1 -> shadow=0, o_w_an=1111 and o_w_7seg=0 for that cycle, then digit 0 restarts with a full 4-cycle slot. PRESCALE=1, DIGITS=1 -> o_w_an=0 constant, o_w_frame high every cycle after the first.
